// File: rtl/mux_sel_arbiter_4.sv
// Four-requester round-robin arbiter that drives the select of mux_4x1 and holds the grant until ack.
// Optional watchdog withdraws an unacknowledged grant; enable it by defining ARB_TIMEOUT_EN.
module mux_sel_arbiter_4 #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("mux_sel_arbiter_4: TIMEOUT must be in 2..255");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;

    logic [1:0] arb_base;
    logic [1:0] win_idx;
    logic       win_found;

    // While granted, an ack moves the pointer to sel in the same cycle, so arbitrate from sel.
    always_comb begin
        arb_base  = (state_q == StGrant) ? sel_q : ptr_q;
        win_idx   = arb_base;
        win_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!win_found && req[arb_base + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = arb_base + 2'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    valid_d = 1'b1;
                    state_d = StGrant;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            StGrant: begin
                if (ack) begin
                    ptr_d = sel_q;
                    if (win_found) begin
                        sel_d   = win_idx;
                        grant_d = 4'b0001 << win_idx;
`ifdef ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CntMax) begin
                    ptr_d     = sel_q;
                    grant_d   = 4'b0000;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign sel   = sel_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule
